// File: rtl/bus_access_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : bus_access_arbiter
//  Purpose  : Arbitrates NUM_CH requesters onto a single APB-like master port.
//             Fixed-priority (ch0 highest) or round-robin grant, wait states
//             via ready, optional access timeout reported as an error.
//  Ports    : clk, rst (async, active-low)
//             chReq/chAddr/chWrite/chWdata  - per-channel request side
//             chAck/chRdata/chErr           - completion pulse, data, error
//             addr/select/enable/write/wdata/rdata/ready - bus master port
//  Revision : 1.0 - initial release
// ============================================================================
module bus_access_arbiter #(
  parameter int NUM_CH         = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            chReq,
  input  logic [NUM_CH*ADDR_WIDTH-1:0] chAddr,
  input  logic [NUM_CH-1:0]            chWrite,
  input  logic [NUM_CH*DATA_WIDTH-1:0] chWdata,
  output logic [NUM_CH-1:0]            chAck,
  output logic [DATA_WIDTH-1:0]        chRdata,
  output logic                         chErr,
  output logic [ADDR_WIDTH-1:0]        addr,
  output logic                         select,
  output logic                         enable,
  output logic                         write,
  output logic [DATA_WIDTH-1:0]        wdata,
  input  logic [DATA_WIDTH-1:0]        rdata,
  input  logic                         ready
);

  localparam int PW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  // Count value on the last permitted wait cycle; only used when a timeout exists.
  localparam logic [CW-1:0] c_cnt_last = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [PW-1:0]           r_gnt;
  logic [PW-1:0]           r_ptr;
  logic [CW-1:0]           r_cnt;
  logic [NUM_CH-1:0]       r_ack;
  logic [DATA_WIDTH-1:0]   r_rdata;
  logic                    r_err;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_sel;
  logic                    r_en;
  logic                    r_write;
  logic [DATA_WIDTH-1:0]   r_wdata;

  logic [NUM_CH-1:0]       w_elig;
  logic                    w_found;
  logic [PW-1:0]           w_sel;
  int                      w_idx;
  logic [NUM_CH-1:0]       w_gnt_oh;
  logic                    w_tick;
  logic                    w_timeout;
  logic [PW-1:0]           w_ptr_nxt;

  // Arbitration. In DONE the channel just served is masked so that a
  // requester still holding chReq during its ack cycle is not re-granted.
  always_comb begin
    w_elig  = chReq;
    w_found = 1'b0;
    w_sel   = '0;
    w_idx   = 0;
    if (r_state == ST_DONE) begin
      w_elig[r_gnt] = 1'b0;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = (ARB_MODE == 1) ? (int'(r_ptr) + i) : i;
      if (w_idx >= NUM_CH) begin
        w_idx = w_idx - NUM_CH;
      end
      if (!w_found && w_elig[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_idx[PW-1:0];
      end
    end
  end

  always_comb begin
    w_gnt_oh        = '0;
    w_gnt_oh[r_gnt] = 1'b1;
    w_ptr_nxt       = (int'(r_gnt) == NUM_CH - 1) ? '0 : r_gnt + 1'b1;
  end

  // Timeout fires on the wait cycle that brings the count to TIMEOUT_CYCLES.
  assign w_tick = (TIMEOUT_CYCLES != 0) && (r_cnt == c_cnt_last);

  always_comb begin
    w_state_nxt = r_state;
    w_timeout   = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_found) w_state_nxt = ST_SETUP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: begin
        if (ready) begin
          w_state_nxt = ST_DONE;
        end else if (w_tick) begin
          w_state_nxt = ST_DONE;
          w_timeout   = 1'b1;
        end
      end
      ST_DONE:   w_state_nxt = w_found ? ST_SETUP : ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // All outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_gnt   <= '0;
      r_ptr   <= '0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
      r_addr  <= '0;
      r_sel   <= 1'b0;
      r_en    <= 1'b0;
      r_write <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sel   <= (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
      r_en    <= (w_state_nxt == ST_ACCESS);
      r_ack   <= '0;
      r_err   <= 1'b0;
      if (w_state_nxt == ST_SETUP) begin
        r_gnt   <= w_sel;
        r_addr  <= chAddr[int'(w_sel)*ADDR_WIDTH +: ADDR_WIDTH];
        r_write <= chWrite[w_sel];
        r_wdata <= chWdata[int'(w_sel)*DATA_WIDTH +: DATA_WIDTH];
        r_cnt   <= '0;
      end
      if (r_state == ST_ACCESS && !ready) begin
        r_cnt <= r_cnt + 1'b1;
      end
      if (r_state == ST_ACCESS && w_state_nxt == ST_DONE) begin
        r_ack   <= w_gnt_oh;
        r_err   <= w_timeout;
        r_rdata <= (ready && !r_write) ? rdata : '0;
        r_ptr   <= w_ptr_nxt;
      end
    end
  end

  assign chAck   = r_ack;
  assign chRdata = r_rdata;
  assign chErr   = r_err;
  assign addr    = r_addr;
  assign select  = r_sel;
  assign enable  = r_en;
  assign write   = r_write;
  assign wdata   = r_wdata;

endmodule
`default_nettype wire
